// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// access-size codes and error-cause codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus.
//   bus_req_o   request, held high for the whole access
//   bus_we_o    1 = write
//   bus_addr_o  word-aligned address
//   bus_be_o    byte enables, bit n = lane [8n+7:8n]
//   bus_wdata_o write data, replicated across lanes
//   bus_ack_i   completion; read data valid in the same cycle
//   bus_rdata_i read data
// master = load/store unit, slave = memory.
interface load_store_unit_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Purely combinational lane steering for the load/store unit.
//   Write side: wr_size/wr_offset/store_data -> be, wdata (replicated lanes).
//   Read side:  rd_size/rd_offset/rd_unsigned/rdata -> load_data
//               (lane selected, then sign- or zero-extended).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_offset,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_offset,
  input  logic        rd_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_ext_s;
  logic signed [31:0] half_ext_s;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (wr_size)
      SZ_BYTE: begin
        be    = 4'b0001 << wr_offset;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be    = wr_offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    byte_s     = rdata[{rd_offset, 3'b000} +: 8];
    half_s     = rd_offset[1] ? rdata[31:16] : rdata[15:0];
    // signed-to-signed assignment performs the sign extension
    byte_ext_s = byte_s;
    half_ext_s = half_s;
    load_data  = 32'h0;
    case (rd_size)
      SZ_BYTE: load_data = rd_unsigned ? {24'h0, byte_s} : byte_ext_s;
      SZ_HALF: load_data = rd_unsigned ? {16'h0, half_s} : half_ext_s;
      SZ_WORD: load_data = rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage behind the ALU. Runs one lw/lh/lhu/lb/lbu/sw/sh/sb
// transaction on a req/ack bus and stalls the datapath with busy_o meanwhile.
//   clk, reset (async, active low)
//   mem_read_i/mem_write_i/mem_size_i/unsigned_i : access request from control
//   address_i, store_data_i                      : effective address, rt value
//   busy_o      stall, combinational from inputs while idle
//   done_o      one-cycle completion pulse
//   load_data_o extended load result, held until the next completed load
//   err_o       one-cycle abort pulse; err_cause_o held until next error
//   bus         req/ack memory bus (master side)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic [1:0]                mem_size_i,
  input  logic                      unsigned_i,
  input  logic [31:0]               address_i,
  input  logic [31:0]               store_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [31:0]               load_data_o,
  output logic                      err_o,
  output logic [1:0]                err_cause_o,
  load_store_unit_if.master         bus
);

  lsu_state_t  state_q, state_d;
  logic [7:0]  cnt_q;
  logic [1:0]  cause_d;
  logic        start;
  logic        illegal;
  logic        misalign;

  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] load_q;
  logic [1:0]  cause_q;

  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] load_ext;

  lsu_lane_align u_align (
    .wr_size     (mem_size_i),
    .wr_offset   (address_i[1:0]),
    .store_data  (store_data_i),
    .be          (be_new),
    .wdata       (wdata_new),
    .rd_size     (size_q),
    .rd_offset   (off_q),
    .rd_unsigned (uns_q),
    .rdata       (bus.bus_rdata_i),
    .load_data   (load_ext)
  );

  assign start    = mem_read_i | mem_write_i;
  assign illegal  = (mem_read_i & mem_write_i) | (mem_size_i == SZ_ILL);
  assign misalign = ((mem_size_i == SZ_WORD) && (address_i[1:0] != 2'b00)) ||
                    ((mem_size_i == SZ_HALF) && address_i[0]);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (illegal) begin
            state_d = ST_ERR;
            cause_d = CAUSE_ILLEGAL;
          end else if (misalign) begin
            state_d = ST_ERR;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // ack wins over an expiring timeout on the same edge
        if (bus.bus_ack_i) begin
          state_d = ST_DONE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ERR;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      cause_q <= CAUSE_NONE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      load_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;

      if ((state_q == ST_REQ) && (state_d == ST_REQ)) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= 8'd0;
      end

      if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
        req_q   <= 1'b1;
        we_q    <= mem_write_i;
        addr_q  <= {address_i[31:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= wdata_new;
        size_q  <= mem_size_i;
        uns_q   <= unsigned_i;
        off_q   <= address_i[1:0];
      end else if ((state_q == ST_REQ) && (state_d != ST_REQ)) begin
        req_q <= 1'b0;
        we_q  <= 1'b0;
        be_q  <= 4'h0;
      end

      if ((state_q == ST_REQ) && bus.bus_ack_i && !we_q) begin
        load_q <= load_ext;
      end
    end
  end

  assign busy_o      = ((state_q == ST_IDLE) && start) || (state_q == ST_REQ);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_ERR);
  assign err_cause_o = cause_q;
  assign load_data_o = load_q;

  assign bus.bus_req_o   = req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_be_o    = be_q;
  assign bus.bus_wdata_o = wdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage directly downstream of the ALU. It takes the ALU result as effective address and the rt register value as store data, and runs a lw/lh/lhu/lb/lbu/sw/sh/sb transaction on a req/ack memory bus. It stalls the single-cycle datapath via `busy_o` until the access completes, then returns lane-aligned, sign- or zero-extended load data to the write-back mux.

## Interface
- `TIMEOUT_CYCLES`, 16: max REQ cycles without `bus_ack_i` before abort; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_read_i`  in  1  load requested by main control.
- `mem_write_i`  in  1  store requested by main control.
- `mem_size_i`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_i`  in  1  1 = zero-extend loads (lbu/lhu); ignored for words and stores.
- `address_i`  in  32  effective address (`alu_data_o`).
- `store_data_i`  in  32  rt value; the low byte or half is used for sb/sh.
- `busy_o`  out  1  stall: the PC and register file must hold while this is 1.
- `done_o`  out  1  one-cycle pulse when the access completes.
- `load_data_o`  out  32  extended load result; holds its value until the next completed load.
- `err_o`  out  1  one-cycle pulse on an aborted access.
- `err_cause_o`  out  2  01 misaligned, 10 timeout, 11 illegal op; held until the next error.
- `bus_req_o`  out  1  bus request; registered.
- `bus_we_o`  out  1  1 = write.
- `bus_addr_o`  out  32  word address: `{address_i[31:2], 2'b00}`.
- `bus_be_o`  out  4  byte enables; bit n selects byte lane `[8n+7:8n]`.
- `bus_wdata_o`  out  32  store data, replicated to all lanes.
- `bus_ack_i`  in  1  completion; read data is valid in the same cycle.
- `bus_rdata_i`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, DONE, ERR. Reset enters IDLE.
- A start is `(mem_read_i | mem_write_i)` sampled in IDLE. Start is never evaluated in REQ, DONE or ERR, so an instruction whose control lines are still asserted is not restarted.
- IDLE on a start goes to ERR if any of these hold:
  - both `mem_read_i` and `mem_write_i` are 1 (cause 11);
  - `mem_size_i` is 11 (cause 11);
  - a word access has `address_i[1:0] != 0` (cause 01);
  - a half access has `address_i[0] != 0` (cause 01).
- Otherwise IDLE goes to REQ. On that edge the unit latches `bus_addr_o`, `bus_we_o`, `bus_be_o`, `bus_wdata_o`, the size/unsigned flags and the byte offset.
- REQ:
  - `bus_req_o` = 1 and all bus outputs are stable.
  - On `bus_ack_i`, go to DONE; for a load, capture extended `bus_rdata_i` into `load_data_o` on that edge.
  - If `TIMEOUT_CYCLES` REQ cycles elapse with no ack, go to ERR with cause 10.
- DONE: `done_o` = 1; unconditionally go to IDLE.
- ERR: `err_o` = 1; unconditionally go to IDLE. No bus request is ever issued for cause 01 or 11.
- Byte enables:
  - byte: one-hot at `address_i[1:0]`;
  - half: 0011 or 1100 selected by `address_i[1]`;
  - word: 1111;
  - all zero when no request is active.
- Write data: byte is `{4{sd[7:0]}}`, half is `{2{sd[15:0]}}`, word passes through unchanged. Little-endian lanes.
- Load extension: select the lane by the latched offset, then sign-extend, or zero-extend if `unsigned_i`.
- `bus_ack_i` outside REQ is ignored.

## Timing
- `busy_o` = (IDLE & start) | REQ; it is combinational from the inputs in IDLE.
- `bus_req_o` rises one cycle after the start cycle.
- Minimum access (ack in the first REQ cycle): start cycle + 1 REQ cycle + DONE cycle. `busy_o` is high for 2 cycles and the PC advances on the edge ending DONE.
- Timeout abort: `busy_o` is high for 1 + `TIMEOUT_CYCLES` cycles, then ERR.
- Reset values: state IDLE, all outputs 0 including `load_data_o` and `err_cause_o`, timeout counter 0.
- Reset asserted mid-REQ drops `bus_req_o` immediately (asynchronous). A pending ack is lost and no `done_o` is produced.
- An ack arriving on the same edge as timeout expiry counts as success: go to DONE, not ERR.

## Structure
- Shared package `lsu_pkg`: state enum, size codes (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), error cause codes.
- One sub-module, `lsu_lane_align`: purely combinational. Computes `be`/`wdata` from size/offset/store data, and extends read data from size/offset/unsigned.

## Test plan
- sw, addr 0x1000_0004, data 0xDEADBEEF, ack in first REQ -> be 1111, wdata 0xDEADBEEF, busy 2 cycles, `done_o` pulse.
- lb, addr 0x0000_0003, rdata 0x80112233, then lbu same -> `load_data_o` 0xFFFFFF80, then 0x00000080.
- sh, addr 0x0000_0002, data 0x0000_ABCD, ack after 3 cycles -> be 1100, wdata 0xABCDABCD, busy 5 cycles.
- lw, addr 0x0000_0006 -> no `bus_req_o`, `err_o` pulse, cause 01; size 11 -> cause 11.
- lw with ack withheld, `TIMEOUT_CYCLES`=4 -> req high 4 cycles, then `err_o` with cause 10; late ack ignored.
- reset low during REQ -> `bus_req_o` falls asynchronously, all outputs 0; the next lw completes normally.
